// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit CPU.
// Define CPU_SEQ_SINGLE_STEP_EN to add the step port and the PAUSE state.
module cpu_seq #(
  parameter int ADDR_W      = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              imem_ack,
  input  logic [8:0]        IMEM_DATA,
  output logic [8:0]        INS,
  input  logic              dec_write_en,
  output logic              rf_we,
  output logic              busy,
  output logic              halted
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
`ifdef CPU_SEQ_SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [8:0]         ins;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers advance according to the state being left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      ins <= '0;
      cnt <= '0;
    end else begin
      case (state)
        FETCH:     if (imem_ack) ins <= IMEM_DATA;
        DECODE: begin
          if (!ins[8])      cnt <= CNT_W'(EXEC_CYCLES - 1);
          else if (!ins[7]) pc  <= ins[ADDR_W-1:0];
        end
        EXECUTE:   if (cnt != '0) cnt <= cnt - CNT_W'(1);
        WRITEBACK: pc <= pc + ADDR_W'(1);
        HALT:      if (start) pc <= '0;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = FETCH;
      FETCH:     if (imem_ack) state_nxt = DECODE;
      DECODE: begin
        if (!ins[8])      state_nxt = EXECUTE;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        else if (!ins[7]) state_nxt = PAUSE;
`else
        else if (!ins[7]) state_nxt = FETCH;
`endif
        else              state_nxt = HALT;
      end
      EXECUTE:   if (cnt == '0) state_nxt = WRITEBACK;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      WRITEBACK: state_nxt = PAUSE;
      PAUSE:     if (step) state_nxt = FETCH;
`else
      WRITEBACK: state_nxt = FETCH;
`endif
      HALT:      if (start) state_nxt = FETCH;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH);
    rf_we    = (state == WRITEBACK) && dec_write_en;
    halted   = (state == HALT);
    busy     = (state == FETCH) || (state == DECODE) ||
               (state == EXECUTE) || (state == WRITEBACK);
`ifdef CPU_SEQ_SINGLE_STEP_EN
    if (state == PAUSE) busy = 1'b1;
`endif
  end

  assign IMEM_ADDR = pc;
  assign INS       = ins;

endmodule
